// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle main control FSM for the MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback over one shared ALU and a
// unified memory. Memory states handshake on i_mem_ready and give up after
// WAIT_LIMIT cycles without it.
//
// Ports:
//   i_clk, i_reset        clock (rising edge), synchronous active-high reset
//   i_opcode, i_funct     IR[31:26], IR[5:0]
//   i_mem_ready           memory completes the current access this cycle
//   o_pc_write .. o_alu_src_a   datapath strobes / selects
//   o_alu_src_b           00 B, 01 const 4, 10 sext imm, 11 imm<<2
//   o_pc_source           00 ALU, 01 ALUOut, 10 jump target, 11 rs
//   o_alu_op              00 add, 01 sub, 10 R-type, 11 ori
//   o_state               current state (debug)
//   o_instr_done          pulse in the last cycle of each instruction
//   o_illegal             pulse in DECODE on an unsupported opcode
//   o_mem_timeout         pulse when a memory wait hits WAIT_LIMIT
//
// state  | meaning
// FETCH  | read instruction at PC, PC += 4 on mem_ready
// DECODE | register read, branch target into ALUOut
// MEMADR | lw/sw effective address
// MEMRD  | load data read
// MEMWB  | load writeback
// MEMWR  | store data write
// RTEXEC | R-type ALU operation
// RTWB   | R-type writeback to rd
// BRANCH | beq compare, conditional PC load
// JUMP   | j target into PC
// IEXEC  | addi/ori ALU operation
// IWB    | immediate writeback to rt
// JREG   | jr: rs into PC

module mc_ctrl_fsm #(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 5
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  input  logic       i_mem_ready,
  output logic       o_pc_write,
  output logic       o_pc_write_cond,
  output logic       o_i_or_d,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_mem_to_reg,
  output logic       o_ir_write,
  output logic       o_reg_write,
  output logic       o_reg_dst,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_pc_source,
  output logic [1:0] o_alu_op,
  output logic [3:0] o_state,
  output logic       o_instr_done,
  output logic       o_illegal,
  output logic       o_mem_timeout
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXEC = 4'd6,
    S_RTWB   = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_JREG   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] w_wait_cnt_nxt;
  logic             w_waiting;
  logic             w_timeout;

  assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  // mem_ready in the final wait cycle completes normally instead of timing out
  assign w_timeout = w_waiting && !i_mem_ready && (r_wait_cnt == LP_CNT_LAST);

  // Counter runs only while a memory state holds; every exit (including a
  // timeout back into FETCH) leaves it at zero for the next wait.
  assign w_wait_cnt_nxt = (w_waiting && !i_mem_ready && !w_timeout) ? r_wait_cnt + 1'b1
                                                                    : '0;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    o_pc_write      = 1'b0;
    o_pc_write_cond = 1'b0;
    o_i_or_d        = 1'b0;
    o_mem_read      = 1'b0;
    o_mem_write     = 1'b0;
    o_mem_to_reg    = 1'b0;
    o_ir_write      = 1'b0;
    o_reg_write     = 1'b0;
    o_reg_dst       = 1'b0;
    o_alu_src_a     = 1'b0;
    o_alu_src_b     = 2'b00;
    o_pc_source     = 2'b00;
    o_alu_op        = 2'b00;
    o_instr_done    = 1'b0;
    o_illegal       = 1'b0;

    case (r_state)
      S_FETCH: begin
        o_mem_read  = 1'b1;
        o_alu_src_b = 2'b01;
        if (i_mem_ready) begin
          o_ir_write  = 1'b1;
          o_pc_write  = 1'b1;
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        o_alu_src_b = 2'b11;
        case (i_opcode)
          OP_LW, OP_SW:    w_state_nxt = S_MEMADR;
          OP_RTYPE:        w_state_nxt = (i_funct == FN_JR) ? S_JREG : S_RTEXEC;
          OP_BEQ:          w_state_nxt = S_BRANCH;
          OP_J:            w_state_nxt = S_JUMP;
          OP_ADDI, OP_ORI: w_state_nxt = S_IEXEC;
          default: begin
            o_illegal   = 1'b1;
            w_state_nxt = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = 2'b10;
        w_state_nxt = (i_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        o_mem_read = 1'b1;
        o_i_or_d   = 1'b1;
        if (i_mem_ready) begin
          w_state_nxt = S_MEMWB;
        end else if (w_timeout) begin
          w_state_nxt = S_FETCH;
        end
      end
      S_MEMWB: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = 1'b1;
        o_instr_done = 1'b1;
        w_state_nxt  = S_FETCH;
      end
      S_MEMWR: begin
        o_mem_write = 1'b1;
        o_i_or_d    = 1'b1;
        if (i_mem_ready) begin
          o_instr_done = 1'b1;
          w_state_nxt  = S_FETCH;
        end else if (w_timeout) begin
          w_state_nxt = S_FETCH;
        end
      end
      S_RTEXEC: begin
        o_alu_src_a = 1'b1;
        o_alu_op    = 2'b10;
        w_state_nxt = S_RTWB;
      end
      S_RTWB: begin
        o_reg_write  = 1'b1;
        o_reg_dst    = 1'b1;
        o_instr_done = 1'b1;
        w_state_nxt  = S_FETCH;
      end
      S_BRANCH: begin
        o_alu_src_a     = 1'b1;
        o_alu_op        = 2'b01;
        o_pc_write_cond = 1'b1;
        o_pc_source     = 2'b01;
        o_instr_done    = 1'b1;
        w_state_nxt     = S_FETCH;
      end
      S_JUMP: begin
        o_pc_write   = 1'b1;
        o_pc_source  = 2'b10;
        o_instr_done = 1'b1;
        w_state_nxt  = S_FETCH;
      end
      S_JREG: begin
        o_pc_write   = 1'b1;
        o_pc_source  = 2'b11;
        o_instr_done = 1'b1;
        w_state_nxt  = S_FETCH;
      end
      S_IEXEC: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = 2'b10;
        o_alu_op    = (i_opcode == OP_ORI) ? 2'b11 : 2'b00;
        w_state_nxt = S_IWB;
      end
      S_IWB: begin
        o_reg_write  = 1'b1;
        o_instr_done = 1'b1;
        w_state_nxt  = S_FETCH;
      end
      default: w_state_nxt = S_FETCH;
    endcase
  end

  assign o_mem_timeout = w_timeout;
  assign o_state       = r_state;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm. Each cycle drives opcode/funct/mem_ready,
// then compares the state and a packed control word against hand-derived
// constants before the next rising edge.

module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg;
  logic       ir_write, reg_write, reg_dst, alu_src_a;
  logic [1:0] alu_src_b, pc_source, alu_op;
  logic [3:0] state;
  logic       instr_done, illegal, mem_timeout;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.WAIT_LIMIT(4), .CNT_W(5)) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_opcode       (opcode),
    .i_funct        (funct),
    .i_mem_ready    (mem_ready),
    .o_pc_write     (pc_write),
    .o_pc_write_cond(pc_write_cond),
    .o_i_or_d       (i_or_d),
    .o_mem_read     (mem_read),
    .o_mem_write    (mem_write),
    .o_mem_to_reg   (mem_to_reg),
    .o_ir_write     (ir_write),
    .o_reg_write    (reg_write),
    .o_reg_dst      (reg_dst),
    .o_alu_src_a    (alu_src_a),
    .o_alu_src_b    (alu_src_b),
    .o_pc_source    (pc_source),
    .o_alu_op       (alu_op),
    .o_state        (state),
    .o_instr_done   (instr_done),
    .o_illegal      (illegal),
    .o_mem_timeout  (mem_timeout)
  );

  logic [18:0] ctrl;
  assign ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg,
                 ir_write, reg_write, reg_dst, alu_src_a, alu_src_b, pc_source,
                 alu_op, instr_done, illegal, mem_timeout};

  localparam logic [18:0] B_PCW  = 19'h1 << 18;
  localparam logic [18:0] B_PCWC = 19'h1 << 17;
  localparam logic [18:0] B_IORD = 19'h1 << 16;
  localparam logic [18:0] B_MR   = 19'h1 << 15;
  localparam logic [18:0] B_MW   = 19'h1 << 14;
  localparam logic [18:0] B_M2R  = 19'h1 << 13;
  localparam logic [18:0] B_IRW  = 19'h1 << 12;
  localparam logic [18:0] B_RW   = 19'h1 << 11;
  localparam logic [18:0] B_RDST = 19'h1 << 10;
  localparam logic [18:0] B_ASA  = 19'h1 << 9;
  localparam logic [18:0] ASB_4  = 19'h1 << 7;
  localparam logic [18:0] ASB_IM = 19'h2 << 7;
  localparam logic [18:0] ASB_SH = 19'h3 << 7;
  localparam logic [18:0] PCS_AO = 19'h1 << 5;
  localparam logic [18:0] PCS_J  = 19'h2 << 5;
  localparam logic [18:0] PCS_RS = 19'h3 << 5;
  localparam logic [18:0] AOP_SB = 19'h1 << 3;
  localparam logic [18:0] AOP_RT = 19'h2 << 3;
  localparam logic [18:0] AOP_OR = 19'h3 << 3;
  localparam logic [18:0] B_DONE = 19'h1 << 2;
  localparam logic [18:0] B_ILL  = 19'h1 << 1;
  localparam logic [18:0] B_TO   = 19'h1;

  localparam logic [18:0] C_FETCH_WAIT = B_MR | ASB_4;
  localparam logic [18:0] C_FETCH_TO   = B_MR | ASB_4 | B_TO;
  localparam logic [18:0] C_FETCH_RDY  = B_PCW | B_MR | B_IRW | ASB_4;
  localparam logic [18:0] C_DECODE     = ASB_SH;
  localparam logic [18:0] C_DECODE_ILL = ASB_SH | B_ILL;
  localparam logic [18:0] C_MEMADR     = B_ASA | ASB_IM;
  localparam logic [18:0] C_MEMRD      = B_IORD | B_MR;
  localparam logic [18:0] C_MEMRD_TO   = B_IORD | B_MR | B_TO;
  localparam logic [18:0] C_MEMWB      = B_RW | B_M2R | B_DONE;
  localparam logic [18:0] C_MEMWR_WAIT = B_MW | B_IORD;
  localparam logic [18:0] C_MEMWR_RDY  = B_MW | B_IORD | B_DONE;
  localparam logic [18:0] C_RTEXEC     = B_ASA | AOP_RT;
  localparam logic [18:0] C_RTWB       = B_RW | B_RDST | B_DONE;
  localparam logic [18:0] C_BRANCH     = B_ASA | AOP_SB | B_PCWC | PCS_AO | B_DONE;
  localparam logic [18:0] C_JUMP       = B_PCW | PCS_J | B_DONE;
  localparam logic [18:0] C_JREG       = B_PCW | PCS_RS | B_DONE;
  localparam logic [18:0] C_IEXEC_ADD  = B_ASA | ASB_IM;
  localparam logic [18:0] C_IEXEC_ORI  = B_ASA | ASB_IM | AOP_OR;
  localparam logic [18:0] C_IWB        = B_RW | B_DONE;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, let outputs settle, compare, then advance a clock.
  task automatic cyc(input string tag, input logic [5:0] op, input logic [5:0] fn,
                     input logic rdy, input logic [3:0] exp_st, input logic [18:0] exp_ctrl);
    opcode    = op;
    funct     = fn;
    mem_ready = rdy;
    #1;
    chk({tag, "_state"}, 32'(state), 32'(exp_st));
    chk({tag, "_ctrl"},  32'(ctrl),  32'(exp_ctrl));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    opcode    = 6'h00;
    funct     = 6'h00;
    mem_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc("reset_fetch", 6'h00, 6'h00, 1'b0, 4'd0, C_FETCH_WAIT);

    // sw, then reset while MEMWR waits
    cyc("sw_fetch",  6'h2B, 6'h00, 1'b1, 4'd0, C_FETCH_RDY);
    cyc("sw_decode", 6'h2B, 6'h00, 1'b1, 4'd1, C_DECODE);
    cyc("sw_memadr", 6'h2B, 6'h00, 1'b0, 4'd2, C_MEMADR);
    mem_ready = 1'b0;
    reset     = 1'b1;
    #1;
    chk("rst_memwr_state", 32'(state), 32'd5);
    chk("rst_memwr_ctrl",  32'(ctrl),  32'(C_MEMWR_WAIT));
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc("rst_after", 6'h2B, 6'h00, 1'b0, 4'd0, C_FETCH_WAIT);

    // lw, mem_ready always high
    cyc("lw_fetch",  6'h23, 6'h00, 1'b1, 4'd0, C_FETCH_RDY);
    cyc("lw_decode", 6'h23, 6'h00, 1'b1, 4'd1, C_DECODE);
    cyc("lw_memadr", 6'h23, 6'h00, 1'b1, 4'd2, C_MEMADR);
    cyc("lw_memrd",  6'h23, 6'h00, 1'b1, 4'd3, C_MEMRD);
    cyc("lw_memwb",  6'h23, 6'h00, 1'b1, 4'd4, C_MEMWB);

    // sw, mem_ready always high
    cyc("sw2_fetch",  6'h2B, 6'h00, 1'b1, 4'd0, C_FETCH_RDY);
    cyc("sw2_decode", 6'h2B, 6'h00, 1'b1, 4'd1, C_DECODE);
    cyc("sw2_memadr", 6'h2B, 6'h00, 1'b1, 4'd2, C_MEMADR);
    cyc("sw2_memwr",  6'h2B, 6'h00, 1'b1, 4'd5, C_MEMWR_RDY);

    // R-type add, then jr
    cyc("add_fetch",  6'h00, 6'h20, 1'b1, 4'd0, C_FETCH_RDY);
    cyc("add_decode", 6'h00, 6'h20, 1'b1, 4'd1, C_DECODE);
    cyc("add_exec",   6'h00, 6'h20, 1'b1, 4'd6, C_RTEXEC);
    cyc("add_wb",     6'h00, 6'h20, 1'b1, 4'd7, C_RTWB);
    cyc("jr_fetch",   6'h00, 6'h08, 1'b1, 4'd0, C_FETCH_RDY);
    cyc("jr_decode",  6'h00, 6'h08, 1'b1, 4'd1, C_DECODE);
    cyc("jr_jreg",    6'h00, 6'h08, 1'b1, 4'd12, C_JREG);

    // beq and j
    cyc("beq_fetch",  6'h04, 6'h00, 1'b1, 4'd0, C_FETCH_RDY);
    cyc("beq_decode", 6'h04, 6'h00, 1'b1, 4'd1, C_DECODE);
    cyc("beq_branch", 6'h04, 6'h00, 1'b1, 4'd8, C_BRANCH);
    cyc("j_fetch",    6'h02, 6'h00, 1'b1, 4'd0, C_FETCH_RDY);
    cyc("j_decode",   6'h02, 6'h00, 1'b1, 4'd1, C_DECODE);
    cyc("j_jump",     6'h02, 6'h00, 1'b1, 4'd9, C_JUMP);

    // ori then addi
    cyc("ori_fetch",   6'h0D, 6'h00, 1'b1, 4'd0, C_FETCH_RDY);
    cyc("ori_decode",  6'h0D, 6'h00, 1'b1, 4'd1, C_DECODE);
    cyc("ori_exec",    6'h0D, 6'h00, 1'b1, 4'd10, C_IEXEC_ORI);
    cyc("ori_wb",      6'h0D, 6'h00, 1'b1, 4'd11, C_IWB);
    cyc("addi_fetch",  6'h08, 6'h00, 1'b1, 4'd0, C_FETCH_RDY);
    cyc("addi_decode", 6'h08, 6'h00, 1'b1, 4'd1, C_DECODE);
    cyc("addi_exec",   6'h08, 6'h00, 1'b1, 4'd10, C_IEXEC_ADD);
    cyc("addi_wb",     6'h08, 6'h00, 1'b1, 4'd11, C_IWB);

    // illegal opcode
    cyc("ill_fetch",  6'h3F, 6'h00, 1'b1, 4'd0, C_FETCH_RDY);
    cyc("ill_decode", 6'h3F, 6'h00, 1'b1, 4'd1, C_DECODE_ILL);
    cyc("ill_back",   6'h3F, 6'h00, 1'b0, 4'd0, C_FETCH_WAIT);

    // FETCH timeout (WAIT_LIMIT=4); ill_back already used wait cycle 1
    cyc("fto_w2",   6'h23, 6'h00, 1'b0, 4'd0, C_FETCH_WAIT);
    cyc("fto_w3",   6'h23, 6'h00, 1'b0, 4'd0, C_FETCH_WAIT);
    cyc("fto_w4",   6'h23, 6'h00, 1'b0, 4'd0, C_FETCH_TO);
    cyc("fto_rst1", 6'h23, 6'h00, 1'b0, 4'd0, C_FETCH_WAIT);
    cyc("fto_rst2", 6'h23, 6'h00, 1'b0, 4'd0, C_FETCH_WAIT);

    // lw with MEMRD timing out
    cyc("rto_fetch",  6'h23, 6'h00, 1'b1, 4'd0, C_FETCH_RDY);
    cyc("rto_decode", 6'h23, 6'h00, 1'b0, 4'd1, C_DECODE);
    cyc("rto_memadr", 6'h23, 6'h00, 1'b0, 4'd2, C_MEMADR);
    cyc("rto_w1",     6'h23, 6'h00, 1'b0, 4'd3, C_MEMRD);
    cyc("rto_w2",     6'h23, 6'h00, 1'b0, 4'd3, C_MEMRD);
    cyc("rto_w3",     6'h23, 6'h00, 1'b0, 4'd3, C_MEMRD);
    cyc("rto_w4",     6'h23, 6'h00, 1'b0, 4'd3, C_MEMRD_TO);
    cyc("rto_after",  6'h23, 6'h00, 1'b0, 4'd0, C_FETCH_WAIT);

    // lw with mem_ready arriving in the last allowed cycle
    cyc("rok_fetch",  6'h23, 6'h00, 1'b1, 4'd0, C_FETCH_RDY);
    cyc("rok_decode", 6'h23, 6'h00, 1'b0, 4'd1, C_DECODE);
    cyc("rok_memadr", 6'h23, 6'h00, 1'b0, 4'd2, C_MEMADR);
    cyc("rok_w1",     6'h23, 6'h00, 1'b0, 4'd3, C_MEMRD);
    cyc("rok_w2",     6'h23, 6'h00, 1'b0, 4'd3, C_MEMRD);
    cyc("rok_w3",     6'h23, 6'h00, 1'b0, 4'd3, C_MEMRD);
    cyc("rok_w4",     6'h23, 6'h00, 1'b1, 4'd3, C_MEMRD);
    cyc("rok_memwb",  6'h23, 6'h00, 1'b0, 4'd4, C_MEMWB);
    cyc("rok_after",  6'h23, 6'h00, 1'b0, 4'd0, C_FETCH_WAIT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
